// File: rtl/video_timing_generator.sv
// Parametrised VESA-style raster timing generator with pixel clock enable,
// selectable sync polarity and a sync/blank delay line for pipeline matching.
module video_timing_generator #(
   parameter int H_ACTIVE   = 800,
   parameter int H_FRONT    = 56,
   parameter int H_SYNC     = 120,
   parameter int H_BACK     = 64,
   parameter int V_ACTIVE   = 600,
   parameter int V_FRONT    = 37,
   parameter int V_SYNC     = 6,
   parameter int V_BACK     = 23,
   parameter int H_SYNC_POL = 0,
   parameter int V_SYNC_POL = 0,
   parameter int COUNT_W    = 11,
   parameter int PIPE_DELAY = 0
) (
   input  logic               in_vga_clk,
   input  logic               in_reset,
   input  logic               in_pixel_en,
   output logic [COUNT_W-1:0] out_pixel_x,
   output logic [COUNT_W-1:0] out_pixel_y,
   output logic               out_blank_n,
   output logic               out_h_sync,
   output logic               out_v_sync,
   output logic               out_line_start,
   output logic               out_frame_start
);

   localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

   if ((longint'(1) << COUNT_W) <= longint'(MAX_TOTAL - 1)) begin : g_bad_count_w
      $error("COUNT_W too narrow for the configured line/frame totals");
   end
   if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
      $error("PIPE_DELAY must be in 0..4");
   end

   typedef logic [COUNT_W-1:0] count_t;

   typedef struct packed {
      logic blank_n;
      logic h_sync;
      logic v_sync;
   } sync_t;

   // Inclusive last positions keep every bound representable in COUNT_W bits.
   localparam count_t H_LAST       = count_t'(H_TOTAL - 1);
   localparam count_t H_ACT_LAST   = count_t'(H_ACTIVE - 1);
   localparam count_t H_SYNC_FIRST = count_t'(H_ACTIVE + H_FRONT);
   localparam count_t H_SYNC_LAST  = count_t'(H_ACTIVE + H_FRONT + H_SYNC - 1);
   localparam count_t V_LAST       = count_t'(V_TOTAL - 1);
   localparam count_t V_ACT_LAST   = count_t'(V_ACTIVE - 1);
   localparam count_t V_SYNC_FIRST = count_t'(V_ACTIVE + V_FRONT);
   localparam count_t V_SYNC_LAST  = count_t'(V_ACTIVE + V_FRONT + V_SYNC - 1);

   localparam logic  H_ASSERT  = (H_SYNC_POL != 0);
   localparam logic  V_ASSERT  = (V_SYNC_POL != 0);
   localparam sync_t SYNC_IDLE = '{blank_n: 1'b0, h_sync: !H_ASSERT, v_sync: !V_ASSERT};

   count_t h_count;
   count_t v_count;
   logic   h_active;
   logic   v_active;
   sync_t  sync_now;
   sync_t  sync_pipe [PIPE_DELAY+1];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge in_vga_clk) begin
      if (in_reset) begin
         h_count <= '0;
         v_count <= '0;
      end else if (in_pixel_en) begin
         if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
         end else begin
            h_count <= h_count + 1'b1;
         end
      end
   end

   always_comb begin
      h_active         = (h_count <= H_ACT_LAST);
      v_active         = (v_count <= V_ACT_LAST);
      sync_now.blank_n = h_active && v_active;
      sync_now.h_sync  = (h_count >= H_SYNC_FIRST && h_count <= H_SYNC_LAST) ? H_ASSERT : !H_ASSERT;
      sync_now.v_sync  = (v_count >= V_SYNC_FIRST && v_count <= V_SYNC_LAST) ? V_ASSERT : !V_ASSERT;
   end

   // Stage 0 of sync_pipe is aligned with the coordinates; later stages add
   // the downstream pixel-pipeline latency, advancing only on enabled cycles.
   always_ff @(posedge in_vga_clk) begin
      if (in_reset) begin
         out_pixel_x     <= '0;
         out_pixel_y     <= '0;
         out_line_start  <= 1'b0;
         out_frame_start <= 1'b0;
         // NOTE: the delay line is a handful of flops, not a RAM, so every stage
         // is reset to idle levels to avoid emitting stale sync after reset.
         for (int i = 0; i <= PIPE_DELAY; i++) begin
            sync_pipe[i] <= SYNC_IDLE;
         end
      end else if (in_pixel_en) begin
         if (h_active && v_active) begin
            out_pixel_x <= h_count;
            out_pixel_y <= v_count;
         end else begin
            out_pixel_x <= '0;
            out_pixel_y <= '0;
         end
         out_line_start  <= (h_count == '0) && v_active;
         out_frame_start <= (h_count == '0) && (v_count == '0);
         sync_pipe[0]    <= sync_now;
         for (int i = 1; i <= PIPE_DELAY; i++) begin
            sync_pipe[i] <= sync_pipe[i-1];
         end
      end
   end

   assign out_blank_n = sync_pipe[PIPE_DELAY].blank_n;
   assign out_h_sync  = sync_pipe[PIPE_DELAY].h_sync;
   assign out_v_sync  = sync_pipe[PIPE_DELAY].v_sync;

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator: default mode, a small delayed mode and a
// small positive-polarity mode, checked against an arithmetic raster model.
module tb_video_timing_generator;

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic        blank_n;
      logic        hs;
      logic        vs;
      logic        ls;
      logic        fs;
   } out_t;

   typedef struct {
      int ha, hf, hs, hb;
      int va, vf, vs, vb;
      int hpol, vpol, pd;
   } mode_t;

   typedef struct {
      logic rst;
      logic en;
      out_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic en;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   mode_t md_dflt  = '{ha:800, hf:56, hs:120, hb:64, va:600, vf:37, vs:6, vb:23, hpol:0, vpol:0, pd:0};
   mode_t md_small = '{ha:8, hf:2, hs:3, hb:1, va:4, vf:1, vs:2, vb:1, hpol:0, vpol:0, pd:2};
   mode_t md_pos   = '{ha:8, hf:2, hs:3, hb:1, va:4, vf:1, vs:2, vb:1, hpol:1, vpol:1, pd:0};

   logic [10:0] d_x, d_y;
   logic        d_b, d_hs, d_vs, d_ls, d_fs;
   logic [3:0]  s_x, s_y;
   logic        s_b, s_hs, s_vs, s_ls, s_fs;
   logic [3:0]  p_x, p_y;
   logic        p_b, p_hs, p_vs, p_ls, p_fs;

   video_timing_generator u_dflt (
      .in_vga_clk(clk), .in_reset(rst), .in_pixel_en(en),
      .out_pixel_x(d_x), .out_pixel_y(d_y), .out_blank_n(d_b),
      .out_h_sync(d_hs), .out_v_sync(d_vs),
      .out_line_start(d_ls), .out_frame_start(d_fs)
   );

   video_timing_generator #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .H_SYNC_POL(0), .V_SYNC_POL(0), .COUNT_W(4), .PIPE_DELAY(2)
   ) u_small (
      .in_vga_clk(clk), .in_reset(rst), .in_pixel_en(en),
      .out_pixel_x(s_x), .out_pixel_y(s_y), .out_blank_n(s_b),
      .out_h_sync(s_hs), .out_v_sync(s_vs),
      .out_line_start(s_ls), .out_frame_start(s_fs)
   );

   video_timing_generator #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .H_SYNC_POL(1), .V_SYNC_POL(1), .COUNT_W(4), .PIPE_DELAY(0)
   ) u_pos (
      .in_vga_clk(clk), .in_reset(rst), .in_pixel_en(en),
      .out_pixel_x(p_x), .out_pixel_y(p_y), .out_blank_n(p_b),
      .out_h_sync(p_hs), .out_v_sync(p_vs),
      .out_line_start(p_ls), .out_frame_start(p_fs)
   );

   out_t act_dflt, act_small, act_pos;
   assign act_dflt  = {d_x, d_y, d_b, d_hs, d_vs, d_ls, d_fs};
   assign act_small = {7'd0, s_x, 7'd0, s_y, s_b, s_hs, s_vs, s_ls, s_fs};
   assign act_pos   = {7'd0, p_x, 7'd0, p_y, p_b, p_hs, p_vs, p_ls, p_fs};

   // Output after m enabled cycles since reset: coordinates/strobes describe
   // raster position m-1, sync/blank describe position m-1-pd (idle if none).
   function automatic out_t model(input mode_t md, input longint m);
      out_t   o;
      int     ht, vt, h, v;
      longint k, ks;
      ht = md.ha + md.hf + md.hs + md.hb;
      vt = md.va + md.vf + md.vs + md.vb;
      o  = '0;
      o.hs = (md.hpol == 0);
      o.vs = (md.vpol == 0);
      if (m == 0) return o;
      k = m - 1;
      h = int'(k % ht);
      v = int'((k / ht) % vt);
      if (h < md.ha && v < md.va) begin
         o.x = 11'(h);
         o.y = 11'(v);
      end
      o.ls = (h == 0) && (v < md.va);
      o.fs = (h == 0) && (v == 0);
      ks = k - md.pd;
      if (ks >= 0) begin
         h = int'(ks % ht);
         v = int'((ks / ht) % vt);
         o.blank_n = (h < md.ha) && (v < md.va);
         o.hs = (h >= md.ha + md.hf && h < md.ha + md.hf + md.hs) ? (md.hpol != 0) : (md.hpol == 0);
         o.vs = (v >= md.va + md.vf && v < md.va + md.vf + md.vs) ? (md.vpol != 0) : (md.vpol == 0);
      end
      return o;
   endfunction

   function automatic out_t mk(input int x, input int y, input logic b, input logic hs,
                               input logic vs, input logic ls, input logic fs);
      out_t o;
      o.x = 11'(x); o.y = 11'(y);
      o.blank_n = b; o.hs = hs; o.vs = vs; o.ls = ls; o.fs = fs;
      return o;
   endfunction

   task automatic check(input string name, input out_t act, input out_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got x=%0d y=%0d b=%b hs=%b vs=%b ls=%b fs=%b, expected x=%0d y=%0d b=%b hs=%b vs=%b ls=%b fs=%b",
                  name, act.x, act.y, act.blank_n, act.hs, act.vs, act.ls, act.fs,
                  exp.x, exp.y, exp.blank_n, exp.hs, exp.vs, exp.ls, exp.fs);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic e);
      @(negedge clk);
      rst = r;
      en  = e;
      @(posedge clk);
      #1;
   endtask

   // Reference position tracked purely from the applied inputs.
   longint m_cnt   = 0;
   bit     m_valid = 1'b0;
   always @(posedge clk) begin
      if (rst) begin
         m_cnt   <= 0;
         m_valid <= 1'b1;
      end else if (en) begin
         m_cnt <= m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("mon_dflt",  act_dflt,  model(md_dflt,  m_cnt));
         check("mon_small", act_small, model(md_small, m_cnt));
         check("mon_pos",   act_pos,   model(md_pos,   m_cnt));
      end
   end

   vec_t vecs [9];
   int   f1, f2, lows, highs, cnt;
   logic prev;

   initial begin
      rst = 1'b1;
      en  = 1'b0;

      // Small delayed mode right after reset, including held and reset rows.
      vecs[0] = '{1'b1, 1'b1, mk(0, 0, 0, 1, 1, 0, 0)};
      vecs[1] = '{1'b0, 1'b1, mk(0, 0, 0, 1, 1, 1, 1)};
      vecs[2] = '{1'b0, 1'b0, mk(0, 0, 0, 1, 1, 1, 1)};
      vecs[3] = '{1'b0, 1'b1, mk(1, 0, 0, 1, 1, 0, 0)};
      vecs[4] = '{1'b0, 1'b1, mk(2, 0, 1, 1, 1, 0, 0)};
      vecs[5] = '{1'b0, 1'b0, mk(2, 0, 1, 1, 1, 0, 0)};
      vecs[6] = '{1'b0, 1'b1, mk(3, 0, 1, 1, 1, 0, 0)};
      vecs[7] = '{1'b1, 1'b0, mk(0, 0, 0, 1, 1, 0, 0)};
      vecs[8] = '{1'b0, 1'b1, mk(0, 0, 0, 1, 1, 1, 1)};
      for (int i = 0; i < 9; i++) begin
         step(vecs[i].rst, vecs[i].en);
         check($sformatf("vec%0d", i), act_small, vecs[i].exp);
      end

      // Default mode: hsync period, hsync low width, active pixels per line.
      step(1'b1, 1'b1);
      prev = d_hs; f1 = -1; f2 = -1; lows = 0; highs = 0;
      for (int i = 1; i <= 2200; i++) begin
         step(1'b0, 1'b1);
         if (prev && !d_hs) begin
            if (f1 < 0) f1 = i;
            else if (f2 < 0) f2 = i;
         end
         if (f1 >= 0 && f2 < 0) begin
            if (!d_hs) lows++;
            if (d_b) highs++;
         end
         prev = d_hs;
      end
      check_int("dflt_hsync_period", f2 - f1, 1040);
      check_int("dflt_hsync_low", lows, 120);
      check_int("dflt_blank_high", highs, 800);

      // Small mode with enable toggling 1,0: line start spacing and width.
      step(1'b1, 1'b0);
      prev = s_ls; f1 = -1; f2 = -1; highs = 0;
      for (int i = 1; i <= 120; i++) begin
         step(1'b0, (i % 2) == 1);
         if (!prev && s_ls) begin
            if (f1 < 0) f1 = i;
            else if (f2 < 0) f2 = i;
         end
         if (f1 >= 0 && f2 < 0 && s_ls) highs++;
         prev = s_ls;
      end
      check_int("toggle_line_clocks", f2 - f1, 28);
      check_int("toggle_ls_high", highs, 2);

      // Small mode frame_start spacing across the simultaneous h/v wrap.
      step(1'b1, 1'b1);
      prev = s_fs; f1 = -1; f2 = -1; highs = 0;
      for (int i = 1; i <= 260; i++) begin
         step(1'b0, 1'b1);
         if (!prev && s_fs) begin
            if (f1 < 0) f1 = i;
            else if (f2 < 0) f2 = i;
         end
         if (f1 >= 0 && f2 < 0 && s_fs) highs++;
         prev = s_fs;
      end
      check_int("frame_period", f2 - f1, 112);
      check_int("frame_start_width", highs, 1);

      // Reset mid-frame at h=5, v=2.
      step(1'b1, 1'b1);
      for (int i = 0; i < 33; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      check("midreset_small", act_small, mk(0, 0, 0, 1, 1, 0, 0));
      check("midreset_pos", act_pos, mk(0, 0, 0, 0, 0, 0, 0));
      step(1'b0, 1'b1);
      check("midreset_first", act_small, mk(0, 0, 0, 1, 1, 1, 1));

      // Random enable pattern with occasional resets, checked by the monitor.
      cnt = 0;
      for (int i = 0; i < 20000; i++) begin
         step($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0);
         cnt++;
      end
      check_int("random_cycles", cnt, 20000);

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
